// File: rtl/mpp_fetch.sv
// Instruction fetch stage for the mpp core: host-loaded program RAM, a program
// counter with stall/jump/halt handling, and one registered instruction per clock.
module mpp_fetch #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [7:0] HALT_OP = 8'hFF,
  parameter logic [7:0] NOP_OP  = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          run,
  input  logic          stall,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic [7:0]    instruction,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [7:0] word;

  assign word = mem[pc];

  // Program RAM is deliberately outside the reset domain so a program
  // survives a reset; the host may only write while not executing.
  always_ff @(posedge clk) begin
    if (load_en && (state != RUN)) begin
      mem[load_addr] <= load_data;
    end
  end

  // running/halted are updated alongside state so they decode it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= NOP_OP;
      running     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (jump_en) begin
            pc          <= jump_addr;
            instruction <= NOP_OP;
          end else if (!stall) begin
            if (word == HALT_OP) begin
              // pc is left on the halt word so the host can see where it stopped.
              instruction <= NOP_OP;
              state       <= HALT;
              running     <= 1'b0;
              halted      <= 1'b1;
            end else begin
              instruction <= word;
              pc          <= pc + AW'(1);
            end
          end
        end
        IDLE, HALT: begin
          instruction <= NOP_OP;
          if (run) begin
            pc      <= '0;
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          pc          <= '0;
          instruction <= NOP_OP;
          running     <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpp_fetch.sv
// Bench for mpp_fetch: vector table for load/run/stall/jump/halt, plus
// hand-written reset, wrap-around and asynchronous-reset sequences.
module tb_mpp_fetch;

  localparam int AW = 4;
  localparam int EW = 8 + AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          run = 1'b0;
  logic          stall = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [7:0]    instruction;
  logic [AW-1:0] pc;
  logic          running;
  logic          halted;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          run;
    logic          stall;
    logic          jump_en;
    logic [AW-1:0] jump_addr;
    logic [7:0]    exp_instr;
    logic [AW-1:0] exp_pc;
    logic          exp_running;
    logic          exp_halted;
  } vec_t;

  vec_t vecs[$];

  mpp_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .run         (run),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instruction (instruction),
    .pc          (pc),
    .running     (running),
    .halted      (halted)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic le, input logic [AW-1:0] la, input logic [7:0] ld,
                       input logic r, input logic s, input logic j, input logic [AW-1:0] ja);
    load_en   = le;
    load_addr = le ? la : AW'($urandom_range(0, 15));
    load_data = le ? ld : 8'($urandom_range(0, 255));
    run       = r;
    stall     = s;
    jump_en   = j;
    jump_addr = j ? ja : AW'($urandom_range(0, 15));
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic le, input logic [AW-1:0] la, input logic [7:0] ld,
                     input logic r, input logic s, input logic j, input logic [AW-1:0] ja,
                     input logic [7:0] ei, input logic [AW-1:0] ep, input logic er,
                     input logic eh);
    vec_t v;
    v.load_en = le; v.load_addr = la; v.load_data = ld; v.run = r; v.stall = s;
    v.jump_en = j; v.jump_addr = ja; v.exp_instr = ei; v.exp_pc = ep;
    v.exp_running = er; v.exp_halted = eh;
    vecs.push_back(v);
  endtask

  // scoreboard
  task automatic push_exp(input logic [7:0] ei, input logic [AW-1:0] ep,
                          input logic er, input logic eh);
    exp_q.push_back({ei, ep, er, eh});
  endtask

  task automatic check_out(input string name);
    logic [EW-1:0] exp;
    logic [EW-1:0] got;
    checks++;
    got = {instruction, pc, running, halted};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got instr=%h pc=%0d running=%0b halted=%0b",
               name, instruction, pc, running, halted);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got instr=%h pc=%0d running=%0b halted=%0b, expected instr=%h pc=%0d running=%0b halted=%0b",
                 name, got[EW-1 -: 8], got[AW+1:2], got[1], got[0],
                 exp[EW-1 -: 8], exp[AW+1:2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    // reset then idle
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      push_exp(8'h00, '0, 1'b0, 1'b0);
      check_out("reset_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      push_exp(8'h00, '0, 1'b0, 1'b0);
      check_out("idle_after_reset");
    end

    // load and run, halt detection
    add(1, 4'd0, 8'h07, 0, 0, 0, 0,  8'h00, 4'd0, 0, 0);
    add(1, 4'd1, 8'h12, 0, 0, 0, 0,  8'h00, 4'd0, 0, 0);
    add(1, 4'd2, 8'h34, 0, 0, 0, 0,  8'h00, 4'd0, 0, 0);
    add(1, 4'd3, 8'hFF, 0, 0, 0, 0,  8'h00, 4'd0, 0, 0);
    add(0, 4'd0, 8'h00, 1, 0, 0, 0,  8'h00, 4'd0, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h07, 4'd1, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h12, 4'd2, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h34, 4'd3, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    // reprogram from HALT; load of word 0 coincides with run
    add(1, 4'd1, 8'h11, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(1, 4'd2, 8'h12, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(1, 4'd3, 8'h13, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(1, 4'd4, 8'h14, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(1, 4'd5, 8'h15, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(1, 4'd6, 8'hFF, 0, 0, 0, 0,  8'h00, 4'd3, 0, 1);
    add(1, 4'd0, 8'h10, 1, 0, 0, 0,  8'h00, 4'd0, 1, 0);
    // load during RUN must be ignored
    add(1, 4'd1, 8'hAA, 0, 0, 0, 0,  8'h10, 4'd1, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h11, 4'd2, 1, 0);
    // stall twice (second with a run that must not restart)
    add(0, 4'd0, 8'h00, 0, 1, 0, 0,  8'h11, 4'd2, 1, 0);
    add(0, 4'd0, 8'h00, 1, 1, 0, 0,  8'h11, 4'd2, 1, 0);
    // jump wins over stall
    add(0, 4'd0, 8'h00, 0, 1, 1, 5,  8'h00, 4'd5, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h15, 4'd6, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h00, 4'd6, 0, 1);
    // restart from HALT; word 1 must still be 11
    add(0, 4'd0, 8'h00, 1, 0, 0, 0,  8'h00, 4'd0, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h10, 4'd1, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h11, 4'd2, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 1, 6,  8'h00, 4'd6, 1, 0);
    add(0, 4'd0, 8'h00, 0, 0, 0, 0,  8'h00, 4'd6, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].load_en, vecs[i].load_addr, vecs[i].load_data, vecs[i].run,
            vecs[i].stall, vecs[i].jump_en, vecs[i].jump_addr);
      push_exp(vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_running, vecs[i].exp_halted);
      cycle();
      check_out($sformatf("vec%0d", i));
    end

    // wrap-around: all words 01, no halt opcode
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, AW'(a), 8'h01, 1'b0, 1'b0, 1'b0, '0);
      push_exp(8'h00, 4'd6, 1'b0, 1'b1);
      cycle();
      check_out("wrap_fill");
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    push_exp(8'h00, 4'd0, 1'b1, 1'b0);
    cycle();
    check_out("wrap_run");
    idle_inputs();
    for (int k = 1; k < 18; k++) begin
      push_exp(8'h01, AW'(k % 16), 1'b1, 1'b0);
      cycle();
      check_out($sformatf("wrap_pc%0d", k));
    end

    // asynchronous reset between edges while running
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 4'd0, 1'b0, 1'b0);
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(8'h00, 4'd0, 1'b0, 1'b0);
    cycle();
    check_out("post_reset_idle");
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    push_exp(8'h00, 4'd0, 1'b1, 1'b0);
    cycle();
    check_out("rerun");
    idle_inputs();
    push_exp(8'h01, 4'd1, 1'b1, 1'b0);
    cycle();
    check_out("ram_retained");

    // final report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpp_fetch.md
Name: mpp_fetch

Overview:
- Instruction fetch stage directly upstream of the mpp core; drives the core's 8-bit instruction input.
- Holds a small program RAM that a host loads over a simple write port.
- On run: sequences a program counter and presents one registered instruction per clock.
- Supports stall, jump redirect and halt-opcode detection; emits NOP (8'h00) whenever it is not actively fetching.

Parameters:
- DEPTH, 16, number of program words (power of two)
- AW, 4, address width, log2(DEPTH)
- HALT_OP, 8'hFF, opcode that stops fetching
- NOP_OP, 8'h00, opcode driven when idle, halted or flushing

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_en  input  1  program RAM write strobe
- load_addr  input  AW  program RAM write address
- load_data  input  8  program RAM write data
- run  input  1  start execution from address 0
- stall  input  1  hold current pc and instruction
- jump_en  input  1  redirect fetch
- jump_addr  input  AW  redirect target
- instruction  output  8  registered instruction to mpp core
- pc  output  AW  address of next word to fetch
- running  output  1  high in RUN state
- halted  output  1  high in HALT state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=0, instruction=NOP_OP, running=0, halted=0.
  - Program RAM contents are not cleared by reset.
- States: IDLE, RUN, HALT; all registers update on the clk rising edge.
- IDLE or HALT:
  - load_en=1 writes load_data to RAM[load_addr].
  - run=1 sets pc=0 and state=RUN; instruction stays NOP_OP this cycle.
  - Load and run in the same cycle: the write completes, and the first fetch (next cycle) returns the written data.
- RUN, precedence per cycle is jump_en > stall > normal fetch:
  - jump_en=1: pc<=jump_addr, instruction<=NOP_OP (one-cycle flush); stall is ignored that cycle.
  - stall=1 (no jump): pc and instruction hold their values.
  - Normal fetch, word w=RAM[pc]:
    - w≠HALT_OP: instruction<=w, pc<=pc+1 modulo DEPTH (DEPTH-1 wraps to 0).
    - w==HALT_OP: instruction<=NOP_OP, pc holds the halt-word address, state<=HALT.
- Latency: RAM[pc] appears on instruction one clock after the edge that samples pc. Back-to-back fetches give one instruction per clock.
- load_en in RUN is ignored; RAM is unchanged.
- run in RUN is ignored; no restart.
- In HALT, run=1 restarts from address 0 as described for IDLE/HALT above.
- running and halted are registered, decode state directly, and are never high together.
- Reset asserted mid-RUN: instruction returns to NOP_OP immediately (asynchronously). Execution resumes only after a new run.

Test Plan:
- Reset then idle:
  - Hold rst_n=0 for 2 clocks, release, wait 3 clocks.
  - Expect instruction=8'h00, pc=0, running=0, halted=0 throughout.
- Load and run:
  - Load RAM[0..3]=8'h07,8'h12,8'h34,8'hFF, then pulse run.
  - Expect instruction=07,12,34 on consecutive cycles, then 00 with halted=1 and pc=3.
- Wrap-around:
  - Fill all 16 words with 8'h01 (no HALT_OP), then run.
  - Expect pc sequence 0..15,0,1, and instruction constant 8'h01 from the second cycle.
- Stall and jump:
  - Program RAM[0..5]=10,11,12,13,14,15 and run.
  - Assert stall for 2 cycles while instruction=11: instruction stays 11 and pc stays 2.
  - Then assert jump_en with jump_addr=5 and stall=1: next instruction=00, then 15.
- Ignored load in RUN:
  - Write RAM[1]=8'hAA while running; it is ignored.
  - After halt, run again: RAM[1] still returns its original value.
- Async reset mid-run:
  - Drop rst_n between clock edges while running.
  - Expect instruction=00 and running=0 before the next edge, and RAM contents retained on the next run.
